// File: rtl/fb_stream_pixel_unpacker.sv
// fb_stream_pixel_unpacker: splits packed framebuffer words into one pixel per beat tagged with tuser/tlast.
module fb_stream_pixel_unpacker #(
    parameter int DATA_WIDTH  = 32,
    parameter int PIXEL_WIDTH = 16,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic                   s_fb_axis_tvalid,
    output logic                   s_fb_axis_tready,
    input  logic                   s_fb_axis_tlast,
    input  logic [DATA_WIDTH-1:0]  s_fb_axis_tdata,
    output logic                   m_vid_axis_tvalid,
    input  logic                   m_vid_axis_tready,
    output logic [PIXEL_WIDTH-1:0] m_vid_axis_tdata,
    output logic                   m_vid_axis_tuser,
    output logic                   m_vid_axis_tlast,
    output logic                   frame_done,
    output logic                   frame_error
);
    localparam int PPB = DATA_WIDTH / PIXEL_WIDTH;
    localparam int IW  = PPB > 1 ? $clog2(PPB) : 1;
    localparam int XW  = H_RES > 1 ? $clog2(H_RES) : 1;
    localparam int YW  = V_RES > 1 ? $clog2(V_RES) : 1;

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] word;
    logic [IW-1:0]         idx;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic                  wlast;
    logic                  rdy_en;
    logic                  full;
    logic                  last_px;
    logic                  x_end;
    logic                  y_end;
    logic                  in_hs;
    logic                  out_hs;

    assign full    = state == HOLD;
    assign last_px = idx == IW'(PPB - 1);
    assign x_end   = x == XW'(H_RES - 1);
    assign y_end   = y == YW'(V_RES - 1);

    // rdy_en keeps tready low while in reset and for the first cycle after release
    assign s_fb_axis_tready  = rdy_en & (!full | (last_px & m_vid_axis_tready));
    assign in_hs             = s_fb_axis_tvalid & s_fb_axis_tready;
    assign out_hs            = full & m_vid_axis_tready;
    assign m_vid_axis_tvalid = full;
    assign m_vid_axis_tdata  = word[idx*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign m_vid_axis_tuser  = full & (x == '0) & (y == '0);
    assign m_vid_axis_tlast  = full & x_end;

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state       <= EMPTY;
            word        <= '0;
            idx         <= '0;
            x           <= '0;
            y           <= '0;
            wlast       <= 1'b0;
            rdy_en      <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rdy_en      <= 1'b1;
            frame_done  <= out_hs & x_end & y_end;
            // a word-final pixel must carry tlast exactly when it closes the frame
            frame_error <= out_hs & last_px & (wlast ^ (x_end & y_end));
            if (out_hs) begin
                idx <= idx + 1'b1;
                x   <= x_end ? '0 : x + 1'b1;
                y   <= x_end ? (y_end ? '0 : y + 1'b1) : y;
                if (last_px & wlast) begin
                    x <= '0;
                    y <= '0;
                end
                if (last_px)
                    state <= EMPTY;
            end
            if (in_hs) begin
                word  <= s_fb_axis_tdata;
                idx   <= '0;
                wlast <= s_fb_axis_tlast;
                state <= HOLD;
            end
        end
    end
endmodule

// File: tb/tb_fb_stream_pixel_unpacker.sv
// tb_fb_stream_pixel_unpacker: table-driven and randomized checks against a frame-position reference model.
module tb_fb_stream_pixel_unpacker;
    localparam int DW  = 32;
    localparam int PW  = 16;
    localparam int H   = 4;
    localparam int V   = 2;
    localparam int PPB = DW / PW;
    localparam int N   = H * V;

    logic          aclk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [PW-1:0] m_tdata;
    logic          m_tuser;
    logic          m_tlast;
    logic          frame_done;
    logic          frame_error;

    fb_stream_pixel_unpacker #(.DATA_WIDTH(DW), .PIXEL_WIDTH(PW), .H_RES(H), .V_RES(V)) dut (
        .aclk(aclk),
        .resetn(resetn),
        .s_fb_axis_tvalid(s_tvalid),
        .s_fb_axis_tready(s_tready),
        .s_fb_axis_tlast(s_tlast),
        .s_fb_axis_tdata(s_tdata),
        .m_vid_axis_tvalid(m_tvalid),
        .m_vid_axis_tready(m_tready),
        .m_vid_axis_tdata(m_tdata),
        .m_vid_axis_tuser(m_tuser),
        .m_vid_axis_tlast(m_tlast),
        .frame_done(frame_done),
        .frame_error(frame_error)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [PW-1:0] d; logic u; logic l; logic wend; logic done; logic err; } pix_t;
    typedef struct { logic [DW-1:0] w; logic l; } word_t;
    typedef struct { logic [DW-1:0] w; logic wl; logic [PW-1:0] p0; logic [PW-1:0] p1;
                     logic u0; logic u1; logic l0; logic l1; } vec_t;

    pix_t  exp_q[$];
    word_t src_q[$];
    int    n_checks = 0, n_fail = 0;
    int    cyc = 0, npix = 0, done_cnt = 0, err_cnt = 0, gaps = 0, last_hs = 0;
    int    gap_epoch = 0, seen_epoch = -1, rel_cnt = 0, p = 0;
    logic  acc = 1'b0, pend_done = 1'b0, pend_err = 1'b0, stall_prev = 1'b0;
    logic [PW+1:0] prev_out = '0;
    logic  auto_src = 1'b0;
    int    src_mode = 0, snk_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pixel must match the next expected entry derived from frame position
    always @(negedge aclk) begin
        pix_t e;
        cyc++;
        if (!resetn) begin
            chk("reset_outputs", {m_tvalid, m_tdata, m_tuser, m_tlast, frame_done, frame_error, s_tready}, 0);
            exp_q.delete();
            p = 0;
            pend_done = 0;
            pend_err = 0;
            acc = 0;
            stall_prev = 0;
            rel_cnt = 0;
        end else begin
            chk("frame_done", frame_done, pend_done);
            chk("frame_error", frame_error, pend_err);
            if (frame_done) done_cnt++;
            if (frame_error) err_cnt++;
            pend_done = 0;
            pend_err = 0;
            if (stall_prev && m_tvalid) chk("stall_stable", {m_tdata, m_tuser, m_tlast}, prev_out);
            if (m_tvalid) begin
                if (exp_q.size() == 0) chk("unexpected_pixel", {m_tvalid, m_tdata}, 0);
                else begin
                    e = exp_q[0];
                    chk("tdata", m_tdata, e.d);
                    chk("tuser", m_tuser, e.u);
                    chk("tlast", m_tlast, e.l);
                    chk("s_tready_full", s_tready, e.wend & m_tready);
                    if (m_tready) begin
                        pend_done = e.done;
                        pend_err = e.err;
                        void'(exp_q.pop_front());
                        npix++;
                        if (seen_epoch == gap_epoch && cyc != last_hs + 1) gaps++;
                        seen_epoch = gap_epoch;
                        last_hs = cyc;
                    end
                end
            end else if (rel_cnt > 0) chk("s_tready_empty", s_tready, 1);
            stall_prev = m_tvalid & !m_tready;
            prev_out = {m_tdata, m_tuser, m_tlast};
            acc = s_tvalid & s_tready;
            if (acc) begin
                for (int k = 0; k < PPB; k++) begin
                    e.d = PW'(s_tdata >> (k * PW));
                    e.u = p == 0;
                    e.l = (p % H) == H - 1;
                    e.wend = k == PPB - 1;
                    e.done = p == N - 1;
                    e.err = e.wend && (s_tlast ? p != N - 1 : p == N - 1);
                    exp_q.push_back(e);
                    p = (e.wend && s_tlast) ? 0 : (p + 1) % N;
                end
            end
            rel_cnt++;
        end
    end

    task automatic push(input logic [DW-1:0] w, input logic l);
        word_t t;
        t.w = w;
        t.l = l;
        src_q.push_back(t);
    endtask

    task automatic push_frame(input logic [DW-1:0] base, input int nw, input logic with_last);
        for (int i = 0; i < nw; i++)
            push(base + DW'(i) * 32'h0002_0002, with_last && i == nw - 1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (k < 600 && !(src_q.size() == 0 && exp_q.size() == 0 && !m_tvalid && !s_tvalid)) begin
            @(negedge aclk);
            k++;
        end
        if (k >= 600) chk({name, "_timeout"}, 1, 0);
        repeat (2) @(negedge aclk);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (k < 50 && !m_tvalid) begin
            @(negedge aclk);
            k++;
        end
        if (k >= 50) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge aclk);
        #2;
        resetn = 0;
        src_q.delete();
        s_tvalid = 0;
        s_tlast = 0;
        s_tdata = '0;
        repeat (cycles) @(posedge aclk);
        #2;
        resetn = 1;
    endtask

    vec_t tbl[4];
    int   d0, e0, g0, n0, sc;

    initial begin
        tbl[0] = '{32'h0002_0001, 1'b0, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'h0004_0003, 1'b0, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{32'h0006_0005, 1'b0, 16'h0005, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h0008_0007, 1'b1, 16'h0007, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b1};
        sc = 0;
        fork
            forever begin
                @(posedge aclk);
                #1;
                if (auto_src) begin
                    if (acc && src_q.size() > 0) void'(src_q.pop_front());
                    if (!(s_tvalid && !acc)) begin
                        if (src_q.size() > 0 && (src_mode == 0 || $urandom_range(2) != 0)) begin
                            s_tvalid = 1;
                            s_tdata = src_q[0].w;
                            s_tlast = src_q[0].l;
                        end else s_tvalid = 0;
                    end
                end
            end
            forever begin
                @(posedge aclk);
                #1;
                sc++;
                m_tready = snk_mode == 0 ? 1'b1 : snk_mode == 1 ? (sc % 4 == 0 || sc % 4 == 3) : 1'($urandom_range(1));
            end
        join_none

        repeat (3) @(posedge aclk);
        #2;
        resetn = 1;

        // nominal frame from the vector table, sink always ready
        d0 = done_cnt;
        e0 = err_cnt;
        @(posedge aclk);
        #1;
        s_tvalid = 1;
        s_tdata = tbl[0].w;
        s_tlast = tbl[0].wl;
        @(negedge aclk);
        for (int i = 0; i < 4; i++) begin
            int k = 0;
            while (!s_tready && k < 20) begin
                @(negedge aclk);
                k++;
            end
            if (k >= 20) chk("tbl_ready_timeout", 1, 0);
            @(posedge aclk);
            #1;
            if (i < 3) begin
                s_tdata = tbl[i+1].w;
                s_tlast = tbl[i+1].wl;
            end else s_tvalid = 0;
            @(negedge aclk);
            chk("tbl_pix0", {m_tvalid, m_tdata, m_tuser, m_tlast}, {1'b1, tbl[i].p0, tbl[i].u0, tbl[i].l0});
            @(negedge aclk);
            chk("tbl_pix1", {m_tvalid, m_tdata, m_tuser, m_tlast}, {1'b1, tbl[i].p1, tbl[i].u1, tbl[i].l1});
        end
        @(negedge aclk);
        chk("tbl_done_pulse", {frame_done, frame_error, m_tvalid}, 3'b100);
        wait_idle("s1");
        chk("s1_done_cnt", done_cnt - d0, 1);
        chk("s1_err_cnt", err_cnt - e0, 0);

        // backpressure with sink pattern 1,0,0,1
        auto_src = 1;
        snk_mode = 1;
        d0 = done_cnt;
        e0 = err_cnt;
        push_frame(32'h0002_0001, 4, 1);
        wait_idle("s2");
        chk("s2_done_cnt", done_cnt - d0, 1);
        chk("s2_err_cnt", err_cnt - e0, 0);
        snk_mode = 0;

        // early tlast, then the next word restarts the frame
        d0 = done_cnt;
        e0 = err_cnt;
        push_frame(32'h0002_0001, 2, 1);
        wait_idle("s3");
        chk("s3_done_cnt", done_cnt - d0, 0);
        chk("s3_err_cnt", err_cnt - e0, 1);
        push(32'h000A_0009, 0);
        wait_valid("s3_next");
        chk("s3_next_pix", {m_tdata, m_tuser}, {16'h0009, 1'b1});
        push_frame(32'h000C_000B, 3, 1);
        wait_idle("s3b");

        // missing tlast: frame wraps with both pulses, then resynchronises
        d0 = done_cnt;
        e0 = err_cnt;
        push_frame(32'h0002_0001, 4, 0);
        push_frame(32'h0012_0011, 4, 1);
        wait_idle("s4");
        chk("s4_done_cnt", done_cnt - d0, 2);
        chk("s4_err_cnt", err_cnt - e0, 1);

        // reset mid-frame discards the partial frame
        push_frame(32'h0002_0001, 4, 1);
        begin
            int k = 0;
            while (npix < 3 + (N * 4 + 6) && k < 100 && exp_q.size() > 0 && npix >= 0) begin
                if (exp_q.size() <= 5) break;
                @(negedge aclk);
                k++;
            end
        end
        do_reset(2);
        push_frame(32'h0022_0021, 4, 1);
        wait_valid("s5");
        chk("s5_first_pix", {m_tdata, m_tuser}, {16'h0021, 1'b1});
        wait_idle("s5");

        // back-to-back frames without bubbles
        @(posedge aclk);
        #2;
        gap_epoch++;
        d0 = done_cnt;
        e0 = err_cnt;
        g0 = gaps;
        n0 = npix;
        push_frame(32'h0002_0001, 4, 1);
        push_frame(32'h0032_0031, 4, 1);
        wait_idle("s6");
        chk("s6_pixels", npix - n0, 16);
        chk("s6_gaps", gaps - g0, 0);
        chk("s6_done_cnt", done_cnt - d0, 2);
        chk("s6_err_cnt", err_cnt - e0, 0);

        // randomized traffic with occasional misplaced tlast
        src_mode = 1;
        snk_mode = 2;
        for (int f = 0; f < 8; f++)
            for (int w = 0; w < 4; w++)
                push($urandom, 1'((w == 3) ^ ($urandom_range(9) == 0)));
        wait_idle("rand");
        src_mode = 0;
        snk_mode = 0;
        push_frame(32'h0042_0041, 4, 1);
        wait_idle("tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fb_stream_pixel_unpacker.md
# fb_stream_pixel_unpacker

Downstream consumer of the RasterIX framebuffer AXI stream (`m_framebuffer_axis_*`). It accepts packed framebuffer words (several pixels per beat), unpacks them into one pixel per beat, and tags each pixel with start-of-frame (`tuser`) and end-of-line (`tlast`) using horizontal and vertical counters. It also reports frame completion and frame-length mismatches against the upstream `tlast`. It sits between the RasterIX framebuffer stream and a display or video-capture sink in simulation and FPGA tops.

## Interface
- DATA_WIDTH, 32, input word width; must be an integer multiple of PIXEL_WIDTH.
- PIXEL_WIDTH, 16, pixel width (RGB565).
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- PPB (local), DATA_WIDTH / PIXEL_WIDTH, pixels per beat.

Ports:
- aclk  in  1  clock.
- resetn  in  1  reset; asynchronous and active-low.
- s_fb_axis_tvalid  in  1  input word valid.
- s_fb_axis_tready  out  1  input word accept.
- s_fb_axis_tlast  in  1  last word of frame.
- s_fb_axis_tdata  in  DATA_WIDTH  packed pixels; pixel 0 is in the LSBs.
- m_vid_axis_tvalid  out  1  pixel valid.
- m_vid_axis_tready  in  1  sink accept.
- m_vid_axis_tdata  out  PIXEL_WIDTH  pixel.
- m_vid_axis_tuser  out  1  high on pixel (0,0).
- m_vid_axis_tlast  out  1  high on pixel x = H_RES-1.
- frame_done  out  1  one-cycle pulse: last pixel of a frame accepted.
- frame_error  out  1  one-cycle pulse: frame length mismatch.

## Operation
- **Registers**
  - `word` (DATA_WIDTH): holds the current input word.
  - `full` (1): `word` holds unsent pixels.
  - `idx` (clog2(PPB)): index of the current pixel within `word`.
  - `wlast` (1): captured `s_fb_axis_tlast`.
  - `x` (clog2(H_RES)) and `y` (clog2(V_RES)): pixel position counters.
- **States**
  - EMPTY (`full`=0) moves to HOLD on an input handshake.
  - HOLD moves back to EMPTY when the output handshake occurs with `idx`=PPB-1 and no new word is accepted in the same cycle.
- **Input acceptance**
  - `s_fb_axis_tready` = !`full` | (`idx`==PPB-1 & `m_vid_axis_tready`).
  - On an input handshake: `word` is loaded, `idx` is set to 0, `wlast` is captured, and `full` is set to 1.
- **Output fields**
  - `m_vid_axis_tvalid` = `full`.
  - `tdata` = `word`[`idx`*PIXEL_WIDTH +: PIXEL_WIDTH].
  - `tuser` = (`x`==0 & `y`==0).
  - `tlast` = (`x`==H_RES-1).
- **On each output handshake**
  - `idx` increments.
  - `x` increments. At H_RES-1, `x` wraps to 0 and `y` increments.
  - At (H_RES-1, V_RES-1), both `x` and `y` wrap to 0 and `frame_done` pulses.
- **Frame synchronisation** (evaluated on the handshake of pixel `idx`==PPB-1):
  - If `wlast`=1, `x` and `y` are forced to 0. If the position was not (H_RES-1, V_RES-1), `frame_error` pulses and `frame_done` does not pulse.
  - If `wlast`=0 and the position is (H_RES-1, V_RES-1), counters wrap normally, `frame_done` pulses, and `frame_error` pulses in the same cycle (missing `tlast`).
- **Output stability:** with `tvalid` high and `tready` low, `tdata`, `tuser` and `tlast` hold stable.

## Timing
- **Reset values:** all outputs, `word`, `full`, `idx`, `wlast`, `x` and `y` are 0 while `resetn`=0. `s_fb_axis_tready` is therefore 1 one cycle after reset release.
- **Latency:** a word accepted at edge N presents pixel 0 valid after edge N.
- **Throughput:** 1 pixel/cycle sustained. A new word loads on the same edge the last pixel of the previous word is consumed, so there are no bubbles.
- **Combinational path:** `s_fb_axis_tready` depends combinationally on `m_vid_axis_tready`. This is permitted; there is no path from `s_fb_axis_tvalid` to `m_vid_axis_tvalid`.
- **Pulse outputs:** `frame_done` and `frame_error` are registered. They are high for exactly the cycle after the qualifying handshake edge.
- **Reset mid-frame:** counters and buffer clear immediately and the partial pixels are discarded. The next accepted word starts at (0,0) with `tuser`=1.
- **Sink backpressure:** a stalled sink stalls the source once the buffer is full. No pixels are dropped or duplicated.

## Test plan
Parameters for all scenarios: H_RES=4, V_RES=2, DATA_WIDTH=32, PIXEL_WIDTH=16.
1. **Nominal frame.** Send words 0x00020001, 0x00040003, 0x00060005, 0x00080007 (last one with tlast), sink always ready.
   - Pixels 1..8 appear on consecutive cycles.
   - `tuser` is high on pixel 1 only; `tlast` is high on pixels 4 and 8.
   - `frame_done` pulses once; `frame_error` stays 0.
2. **Backpressure.** Repeat scenario 1 with sink `tready` toggling 1,0,0,1 repeating.
   - The pixel sequence is identical and `tdata` is stable while stalled.
   - `s_fb_axis_tready` is low whenever `full` is set and the current pixel is not the last one of the word.
3. **Early tlast.** Send 2 words, the second with tlast.
   - `frame_error` pulses after pixel 4 and `frame_done` does not pulse.
   - The next word's pixel 0 has `tuser`=1.
4. **Missing tlast.** Send 4 words with no tlast.
   - `frame_done` and `frame_error` both pulse after pixel 8.
   - Pixel 9 has `tuser`=1.
5. **Reset mid-frame.** After 3 pixels, assert `resetn`=0 for 2 cycles.
   - All outputs are 0 during reset.
   - The next frame starts at (0,0) with its first pixel equal to the LSB half of the first post-reset word.
6. **Back-to-back frames.** Send 2 full frames continuously.
   - 16 pixels with no idle cycles.
   - `frame_done` pulses after pixels 8 and 16.
